// File: rtl/ifp_mem_link.sv
// ifp_mem_link: bit-serial load/exchange link between the frame-buffer sequencer and one ifp PE shift chain.
module ifp_mem_link #(
  parameter int REC_W = 38,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pe_run,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_exchange,
  input  logic [REC_W-1:0] cmd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [REC_W-1:0] rd_data,
  output logic             mem_send,
  output logic             mem_receive,
  output logic             ser_out,
  input  logic             ser_in,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REC_W);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REC_W-1:0] sh_q, sh_d, cap_q, cap_d;
  logic exch_q, exch_d;
  logic send_d, recv_d, ser_d, valid_d, busy_d;
  logic accept, last, shifting;
  assign cmd_ready = !reset && state_q == IDLE && !pe_run && !rd_valid;
  assign accept    = cmd_valid && cmd_ready;
  assign last      = cnt_q == LAST;
  assign shifting  = state_q == SHIFT && !last;
  always_ff @(posedge clock or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && accept) state_d = SHIFT;
    else if (state_q == SHIFT && last) state_d = exch_q ? HOLD : IDLE;
    else if (state_q == HOLD && rd_ready) state_d = IDLE;
  end
  // ser_out and capture trail the strobe by one cycle to match the PE's registered strobe
  always_comb begin
    cnt_d   = accept ? '0 : shifting ? cnt_q + CNT_W'(1) : cnt_q;
    exch_d  = accept ? cmd_exchange : exch_q;
    sh_d    = accept ? cmd_data : shifting ? sh_q >> 1 : sh_q;
    ser_d   = shifting && sh_q[0];
    cap_d   = (state_q == SHIFT && exch_q && cnt_q != '0) ? {ser_in, cap_q[REC_W-1:1]} : cap_q;
    busy_d  = state_d == SHIFT;
    valid_d = state_d == HOLD;
    send_d  = busy_d && cnt_d != LAST && !exch_d;
    recv_d  = busy_d && cnt_d != LAST && exch_d;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt_q       <= '0;
      exch_q      <= 1'b0;
      sh_q        <= '0;
      cap_q       <= '0;
      ser_out     <= 1'b0;
      busy        <= 1'b0;
      rd_valid    <= 1'b0;
      mem_send    <= 1'b0;
      mem_receive <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      exch_q      <= exch_d;
      sh_q        <= sh_d;
      cap_q       <= cap_d;
      ser_out     <= ser_d;
      busy        <= busy_d;
      rd_valid    <= valid_d;
      mem_send    <= send_d;
      mem_receive <= recv_d;
    end
  assign rd_data = cap_q;
endmodule

// File: tb/tb_ifp_mem_link.sv
// tb_ifp_mem_link: scoreboard bench with a behavioural PE shift chain on the serial side.
module tb_ifp_mem_link;
  localparam int W = 38;
  logic clock = 1'b0, reset = 1'b1, pe_run = 1'b0, cmd_valid = 1'b0, cmd_exchange = 1'b0;
  logic rd_ready = 1'b1, ser_in;
  logic [W-1:0] cmd_data = '0;
  logic cmd_ready, rd_valid, mem_send, mem_receive, ser_out, busy;
  logic [W-1:0] rd_data;
  logic [W-1:0] pe = '0, pe_v = '0;
  logic pe_st = 1'b0, pe_ld = 1'b0;
  logic [W-1:0] exp_q[$];
  int n_chk = 0, n_err = 0;

  ifp_mem_link #(.REC_W(W), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .pe_run(pe_run), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_exchange(cmd_exchange), .cmd_data(cmd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .mem_send(mem_send), .mem_receive(mem_receive), .ser_out(ser_out),
    .ser_in(ser_in), .busy(busy)
  );

  always #5 clock = ~clock;

  // PE: strobe registered internally, shifts data_in at MSB, emits bit 0
  assign ser_in = pe[0];
  always @(posedge clock) begin
    pe_st <= mem_send | mem_receive;
    if (pe_ld) pe <= pe_v;
    else if (pe_st) pe <= {ser_out, pe[W-1:1]};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clock)
    if (rd_valid && rd_ready) begin
      chk("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) chk("rd_data", rd_data, exp_q.pop_front());
    end

  task automatic preload(input logic [W-1:0] v);
    @(negedge clock); pe_ld = 1'b1; pe_v = v;
    @(posedge clock); #1 pe_ld = 1'b0;
  endtask

  task automatic send_cmd(input logic [W-1:0] d, input logic x, input logic [W-1:0] e);
    @(negedge clock); cmd_valid = 1'b1; cmd_data = d; cmd_exchange = x;
    for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clock);
    chk("accept", cmd_ready, 1);
    if (x) exp_q.push_back(e);
    @(posedge clock); #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (cmd_ready) break;
    end
    chk("ready_timeout", cmd_ready, 1);
  endtask

  initial begin
    int ns, nr, nb, lat;
    logic seen;
    #2;
    chk("rst_outs", {cmd_ready, rd_valid, mem_send, mem_receive, ser_out, busy}, 0);
    chk("rst_rd_data", rd_data, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_rst", cmd_ready, 1);

    // load only, latency and strobe counts
    send_cmd(38'h2A_5A5A_A5C3, 1'b0, '0);
    ns = 0; nr = 0; nb = 0; lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      ns += int'(mem_send); nr += int'(mem_receive); nb += int'(busy);
      if (cmd_ready) begin lat = i; break; end
    end
    chk("send_cycles", ns, 38);
    chk("recv_cycles", nr, 0);
    chk("busy_cycles", nb, 39);
    chk("ready_latency", lat, 40);
    chk("pe_bright", pe[7:0], 8'hC3);
    chk("pe_cost", pe[15:8], 8'hA5);
    chk("pe_comp", pe[23:16], 8'h5A);
    chk("pe_label", pe[31:24], 8'h5A);
    chk("pe_pred", pe[35:32], 4'hA);
    chk("pe_seed", pe[36], 0);
    chk("pe_changed", pe[37], 1);

    // exchange round trips
    preload(38'h15_1234_5678);
    send_cmd(38'h3F_FFFF_FFFF, 1'b1, 38'h15_1234_5678);
    wait_ready();
    chk("pe_ones", pe, 38'h3F_FFFF_FFFF);
    send_cmd('0, 1'b1, 38'h3F_FFFF_FFFF);
    wait_ready();
    chk("pe_zero", pe, 0);

    // backpressure
    preload(38'h0A_BCDE_F012);
    @(posedge clock); #1 rd_ready = 1'b0;
    send_cmd(38'h11_2233_4455, 1'b1, 38'h0A_BCDE_F012);
    for (int i = 0; i < 100 && !rd_valid; i++) @(negedge clock);
    chk("rd_valid_rise", rd_valid, 1);
    @(posedge clock); #1 cmd_valid = 1'b1; cmd_data = 38'h00_0000_00FF; cmd_exchange = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("bp_rd_data", rd_data, 38'h0A_BCDE_F012);
      chk("bp_ready", cmd_ready, 0);
    end
    @(posedge clock); #1 rd_ready = 1'b1;
    @(posedge clock); #1 rd_ready = 1'b0;
    chk("bp_ready_next", {cmd_ready, rd_valid}, 2'b10);
    @(posedge clock); #1 cmd_valid = 1'b0;
    chk("bp_accept_busy", busy, 1);
    rd_ready = 1'b1;
    wait_ready();
    chk("pe_ff", pe, 38'h00_0000_00FF);

    // run gating
    @(posedge clock); #1 pe_run = 1'b1; cmd_valid = 1'b1; cmd_data = 38'h01_0000_0001;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      seen |= cmd_ready | mem_send | mem_receive | busy;
    end
    chk("run_block", seen, 0);
    @(posedge clock); #1 pe_run = 1'b0;
    @(negedge clock);
    chk("run_drop_ready", cmd_ready, 1);
    @(posedge clock); #1 cmd_valid = 1'b0;
    chk("run_accept", {busy, mem_send}, 2'b11);
    wait_ready();
    chk("pe_run_rec", pe, 38'h01_0000_0001);

    // reset mid-shift
    preload(38'h2B_CAFE_1234);
    send_cmd(38'h12_3456_789A, 1'b1, 38'h2B_CAFE_1234);
    repeat (17) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_outs", {mem_send, mem_receive, busy, ser_out, rd_valid, cmd_ready}, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      seen |= rd_valid;
    end
    chk("no_valid_after_rst", seen, 0);
    preload(38'h05_A5A5_0F0F);
    send_cmd(38'h3A_5A5A_F0F0, 1'b1, 38'h05_A5A5_0F0F);
    wait_ready();
    chk("pe_after_rst", pe, 38'h3A_5A5A_F0F0);
    chk("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
